// File: rtl/lms_fifo_pkg.sv
// Shared constants and helpers for the LMS single-clock FIFO family.
package lms_fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    localparam int ADDR_MIN  = 4;
    localparam int ADDR_MAX  = 10;
    localparam int DATA_MIN  = 1;
    localparam int DATA_MAX  = 256;

    // Level counter must represent 0..2^addr_width inclusive.
    function automatic int lvl_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/lms_sync_fifo_ram.sv
// Single-clock simple-dual-port distributed RAM: synchronous write, asynchronous read.
module lms_sync_fifo_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lms_sync_fifo.sv
// Single-clock distributed-RAM FIFO with standard or FWFT read, programmable
// almost-full/empty thresholds, flush and sticky error flags.
module lms_sync_fifo
    import lms_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REG    = 0,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int            LW       = lvl_width(ADDR_WIDTH);
    localparam int            DEPTH    = 2**ADDR_WIDTH;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] PTR_WRAP = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam bit            IS_FWFT  = (FWFT == MODE_FWFT);
    localparam bit            USE_OREG = !IS_FWFT && (OUT_REG != 0);

    if (ADDR_WIDTH < ADDR_MIN || ADDR_WIDTH > ADDR_MAX) begin : g_bad_addr
        $error("lms_sync_fifo: ADDR_WIDTH out of range");
    end
    if (DATA_WIDTH < DATA_MIN || DATA_WIDTH > DATA_MAX) begin : g_bad_data
        $error("lms_sync_fifo: DATA_WIDTH out of range");
    end

    logic [LW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] dout2_q;
    logic                  vld2_q;

    logic                  wr_acc;
    logic                  pop;
    logic                  ram_rd;
    logic                  ram_empty;
    logic [DATA_WIDTH-1:0] ram_rdata;

    lms_sync_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    // In FWFT mode dout_q/vld_q form the holding register; otherwise they are
    // the first read-data stage. A RAM read refills the holder whenever it is
    // free or being popped, so back-to-back pops see no bubble.
    always_comb begin
        wr_acc    = wr_en & ~full_q;
        pop       = rd_en & ~empty_q;
        ram_empty = (wr_ptr_q == rd_ptr_q);
        ram_rd    = IS_FWFT ? (~ram_empty & (~vld_q | pop)) : pop;

        wr_ptr_d  = wr_ptr_q + LW'(wr_acc);
        rd_ptr_d  = rd_ptr_q + LW'(ram_rd);

        level_d   = level_q;
        if (wr_acc && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !wr_acc) begin
            level_d = level_q - 1'b1;
        end

        vld_d     = ram_rd | (IS_FWFT & vld_q & ~pop);
        dout_d    = ram_rd ? ram_rdata : dout_q;

        // The holder counts toward capacity in FWFT, so full is level based there.
        full_d    = IS_FWFT ? (level_d == DEPTH_L)
                            : ((wr_ptr_d ^ rd_ptr_d) == PTR_WRAP);
        empty_d   = IS_FWFT ? ~vld_d : (wr_ptr_d == rd_ptr_d);

        af_d      = (af_thresh != '0) && (level_d >= af_thresh);
        ae_d      = (level_d <= ae_thresh);

        ovf_d     = (ovf_q & ~clr_err) | (wr_en & full_q);
        udf_d     = (udf_q & ~clr_err) | (rd_en & empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            dout2_q  <= '0;
            vld2_q   <= 1'b0;
            ovf_q    <= rst ? 1'b0 : ovf_d;
            udf_q    <= rst ? 1'b0 : udf_d;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            if (vld_q) begin
                dout2_q <= dout_q;
            end
            vld2_q   <= vld_q;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign rd_data      = USE_OREG ? dout2_q : dout_q;
    assign rd_valid     = USE_OREG ? vld2_q : vld_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign water_level  = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_lms_sync_fifo.sv
// Directed bench: three FIFO flavours (std, FWFT, std+output reg) share one stimulus stream.
module tb_lms_sync_fifo;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW:0]   af_thresh = '0;
    logic [AW:0]   ae_thresh = '0;
    logic          clr_err = 1'b0;

    logic [2:0]    full, rd_valid, empty, almost_full, almost_empty, overflow, underflow;
    logic [DW-1:0] rd_data [3];
    logic [AW:0]   water_level [3];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // 0: standard, 1: FWFT, 2: standard with output register
    for (genvar g = 0; g < 3; g++) begin : g_dut
        lms_sync_fifo #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .OUT_REG    ((g == 2) ? 1 : 0),
            .FWFT       ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush),
            .wr_data      (wr_data),
            .wr_en        (wr_en),
            .full         (full[g]),
            .rd_en        (rd_en),
            .rd_data      (rd_data[g]),
            .rd_valid     (rd_valid[g]),
            .empty        (empty[g]),
            .af_thresh    (af_thresh),
            .ae_thresh    (ae_thresh),
            .almost_full  (almost_full[g]),
            .almost_empty (almost_empty[g]),
            .water_level  (water_level[g]),
            .overflow     (overflow[g]),
            .underflow    (underflow[g]),
            .clr_err      (clr_err)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        // reset state
        chk("rst_empty", empty[0], 1);
        chk("rst_full", full[0], 0);
        chk("rst_level", water_level[0], 0);
        chk("rst_ae", almost_empty[0], 1);
        chk("rst_af", almost_full[0], 0);
        chk("rst_vld", rd_valid[0], 0);
        chk("rst_data", rd_data[0], 0);
        chk("rst_ovf", overflow[0], 0);
        chk("rst_fwft_empty", empty[1], 1);

        // fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = DW'(i);
            tick();
            if (i == 15) chk("fill_notfull15", full[0], 0);
        end
        wr_data = 16'h0011;
        tick();
        wr_en = 1'b0;
        chk("fill_full", full[0], 1);
        chk("fill_level", water_level[0], 16);
        chk("fill_ovf", overflow[0], 1);
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_vld", rd_valid[0], 1);
            chk("drain_data", rd_data[0], i);
        end
        rd_en = 1'b0;
        chk("drain_empty", empty[0], 1);
        tick();
        chk("drain_vld_pulse", rd_valid[0], 0);
        chk("drain_data_hold", rd_data[0], 16'h0010);

        // threshold flags
        do_reset();
        af_thresh = 5'd12; ae_thresh = 5'd3;
        tick();
        for (int i = 1; i <= 12; i++) begin
            wr_en = 1'b1; wr_data = DW'(16'h0200 + i);
            tick();
            chk("thr_wr_af", almost_full[0], (i >= 12));
            chk("thr_wr_ae", almost_empty[0], (i <= 3));
        end
        wr_en = 1'b0;
        af_thresh = 5'd0;
        tick();
        chk("thr_af_disabled", almost_full[0], 0);
        af_thresh = 5'd12;
        tick();
        chk("thr_af_restored", almost_full[0], 1);
        for (int j = 1; j <= 9; j++) begin
            rd_en = 1'b1;
            tick();
            chk("thr_rd_af", almost_full[0], ((12 - j) >= 12));
            chk("thr_rd_ae", almost_empty[0], ((12 - j) <= 3));
        end
        rd_en = 1'b0;
        chk("thr_level3", water_level[0], 3);

        // simultaneous read/write across pointer wrap
        do_reset();
        af_thresh = '0; ae_thresh = '0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = DW'(16'h0100 + i);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(16'h0108 + k);
            tick();
            chk("rw_level", water_level[0], 8);
            chk("rw_data", rd_data[0], 16'h0100 + k);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_en = 1'b1;
            tick();
            chk("rw_tail", rd_data[0], 16'h0114 + k);
        end
        rd_en = 1'b0;
        chk("rw_udf_clear", underflow[0], 0);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h5A5A;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("rw0_level", water_level[0], 1);
        chk("rw0_udf", underflow[0], 1);
        chk("rw0_novld", rd_valid[0], 0);
        rd_en = 1'b1;
        tick();
        chk("rw0_data", rd_data[0], 16'h5A5A);

        // error clear priority: set wins over clr_err, then clr_err alone
        clr_err = 1'b1;
        tick();
        chk("clr_set_wins", underflow[0], 1);
        rd_en = 1'b0;
        tick();
        clr_err = 1'b0;
        chk("clr_alone", underflow[0], 0);

        // FWFT latency and back-to-back pops
        do_reset();
        wr_en = 1'b1; wr_data = 16'hABCD;
        tick();
        wr_en = 1'b0;
        chk("fwft_t1_empty", empty[1], 1);
        tick();
        chk("fwft_t2_empty", empty[1], 0);
        chk("fwft_t2_data", rd_data[1], 16'hABCD);
        chk("fwft_t2_vld", rd_valid[1], 1);
        chk("fwft_t2_level", water_level[1], 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fwft_pop_empty", empty[1], 1);
        wr_en = 1'b1; wr_data = 16'h1111;
        tick();
        wr_data = 16'h2222;
        tick();
        wr_en = 1'b0;
        chk("fwft_head1", rd_data[1], 16'h1111);
        chk("fwft_level2", water_level[1], 2);
        rd_en = 1'b1;
        tick();
        chk("fwft_head2", rd_data[1], 16'h2222);
        chk("fwft_head2_vld", empty[1], 0);
        tick();
        rd_en = 1'b0;
        chk("fwft_end_empty", empty[1], 1);
        chk("fwft_no_udf", underflow[1], 0);

        // flush keeps error flags
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = DW'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        chk("fl_pre_level", water_level[0], 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_level", water_level[0], 0);
        chk("fl_empty", empty[0], 1);
        chk("fl_ovf_kept", overflow[0], 1);
        chk("fl_notfull", full[0], 0);

        // OUT_REG latency, then reset abandons a read in flight
        do_reset();
        wr_en = 1'b1; wr_data = 16'h0A0A;
        tick();
        wr_data = 16'h0B0B;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("oreg_t1_vld", rd_valid[2], 0);
        tick();
        chk("oreg_t2_vld", rd_valid[2], 1);
        chk("oreg_t2_data", rd_data[2], 16'h0A0A);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_vld", rd_valid[2], 0);
        chk("rstmid_data", rd_data[2], 0);
        chk("rstmid_empty", empty[2], 1);
        chk("rstmid_level", water_level[2], 0);
        chk("rstmid_ae", almost_empty[2], 1);
        chk("rstmid_af", almost_full[2], 0);
        chk("rstmid_full", full[2], 0);
        tick();
        chk("rstmid_t2_vld", rd_valid[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
